// File: rtl/updown_count_monitor.sv
// updown_count_monitor: checks a sampled up/down counter stream step by step
// against the direction that was sampled alongside the previous value.
// It reports good/bad steps, wraps, a lock status and a saturating error tally.
// Optional build macro UDMON_ZERO_RESTART_EN: a mismatched sample equal to 0
// is treated as a counter restart (no error, back to ACQUIRE) instead of a
// step error.
//
// Sample interface: valid_in qualifies q_in/choice_in for one rising edge.
// There is no ready; the monitor accepts every valid sample, and valid_in=0
// cycles are ignored without disturbing the checking context.
module updown_count_monitor #(
  parameter int WIDTH    = 4,
  parameter int LOCK_LEN = 4,
  parameter int ERR_W    = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             valid_in,
  input  logic [WIDTH-1:0] q_in,
  input  logic             choice_in,
  output logic             locked,
  output logic             step_ok,
  output logic             step_err,
  output logic             wrap_up,
  output logic             wrap_down,
  output logic [WIDTH-1:0] expected,
  output logic [ERR_W-1:0] err_count,
  output logic [1:0]       state_dbg,
  output logic [3:0]       good_run_dbg
);

  typedef enum logic [1:0] {
    SYNC    = 2'd0,
    ACQUIRE = 2'd1,
    LOCKED  = 2'd2
  } state_t;

  localparam logic [WIDTH-1:0] ONE     = WIDTH'(1);
  localparam logic [WIDTH-1:0] ZERO    = '0;
  localparam logic [WIDTH-1:0] MAXV    = '1;
  localparam logic [ERR_W-1:0] ERR_MAX = '1;
  localparam logic [3:0]       LOCK_V  = 4'(LOCK_LEN);

`ifdef UDMON_ZERO_RESTART_EN
  localparam bit ZERO_RESTART = 1'b1;
`else
  localparam bit ZERO_RESTART = 1'b0;
`endif

  state_t           state, state_n;
  logic [WIDTH-1:0] prev_q, prev_q_n;
  logic             prev_choice, prev_choice_n;
  logic [3:0]       good_run, good_run_n;
  logic             ok_n, err_n, wu_n, wd_n;
  logic [WIDTH-1:0] expected_n;
  logic [ERR_W-1:0] err_count_n;
  logic [WIDTH-1:0] exp_v;
  logic             match;
  logic [3:0]       run_inc;

  assign locked       = (state == LOCKED);
  assign state_dbg    = state;
  assign good_run_dbg = good_run;

  // Next-state, capture and registered-output values for the coming edge.
  always_comb begin
    state_n       = state;
    prev_q_n      = prev_q;
    prev_choice_n = prev_choice;
    good_run_n    = good_run;
    ok_n          = 1'b0;
    err_n         = 1'b0;
    wu_n          = 1'b0;
    wd_n          = 1'b0;
    expected_n    = expected;
    err_count_n   = err_count;
    // The direction applied is the one sampled with the previous value.
    exp_v         = prev_choice ? (prev_q + ONE) : (prev_q - ONE);
    match         = (q_in == exp_v);
    run_inc       = good_run + 4'd1;

    if (valid_in) begin
      prev_q_n      = q_in;
      prev_choice_n = choice_in;
      case (state)
        SYNC: begin
          state_n    = ACQUIRE;
          good_run_n = 4'd0;
        end
        ACQUIRE, LOCKED: begin
          expected_n = exp_v;
          if (match) begin
            ok_n = 1'b1;
            wu_n = prev_choice && (prev_q == MAXV);
            wd_n = !prev_choice && (prev_q == ZERO);
            if (state == ACQUIRE) begin
              good_run_n = run_inc;
              if (run_inc == LOCK_V) state_n = LOCKED;
            end
          end else if (ZERO_RESTART && (q_in == ZERO)) begin
            good_run_n = 4'd0;
            state_n    = ACQUIRE;
          end else begin
            err_n      = 1'b1;
            good_run_n = 4'd0;
            state_n    = ACQUIRE;
            if (err_count != ERR_MAX) err_count_n = err_count + 1'b1;
          end
        end
        default: state_n = SYNC;
      endcase
    end
  end

  // State register plus registered outputs; async reset returns everything to idle.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= SYNC;
      prev_q      <= '0;
      prev_choice <= 1'b0;
      good_run    <= 4'd0;
      step_ok     <= 1'b0;
      step_err    <= 1'b0;
      wrap_up     <= 1'b0;
      wrap_down   <= 1'b0;
      expected    <= '0;
      err_count   <= '0;
    end else begin
      state       <= state_n;
      prev_q      <= prev_q_n;
      prev_choice <= prev_choice_n;
      good_run    <= good_run_n;
      step_ok     <= ok_n;
      step_err    <= err_n;
      wrap_up     <= wu_n;
      wrap_down   <= wd_n;
      expected    <= expected_n;
      err_count   <= err_count_n;
    end
  end

endmodule
